// File: rtl/tdm_mux_rr.sv
// N-channel TDM word mux with direct-select and round-robin scan modes.
// Registered output stage with a valid/ready handshake toward one consumer.
//
// state | meaning
// EMPTY | no word held, y_valid=0
// FULL  | word held in y/y_ch/y_last, waiting for y_ready
module tdm_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            e,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N-1:0]    mask,
  input  logic [N*W-1:0]  d,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   y_ch,
  output logic            y_last,
  output logic            y_valid,
  input  logic            y_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   ptr, ptr_nxt;
  logic [W-1:0]    y_nxt;
  logic [SW-1:0]   ch_nxt;
  logic            last_nxt;
  logic            free;
  logic            s_legal;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    scan_data;
  logic [SW-1:0]   scan_ch;
  logic            scan_hit;
  logic [SW-1:0]   top_ch;

  assign free    = (state == EMPTY) | y_ready;
  assign s_legal = int'(s) < N;
  assign y_valid = (state == FULL);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (s == SW'(i)) sel_data = d[i*W +: W];
    end
  end

  // Walk downward so the candidate closest to ptr is the one that survives.
  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (mask[idx]) begin
        scan_hit = 1'b1;
        scan_ch  = SW'(idx);
      end
    end
  end

  always_comb begin
    scan_data = '0;
    for (int i = 0; i < N; i++) begin
      if (scan_ch == SW'(i)) scan_data = d[i*W +: W];
    end
  end

  always_comb begin
    top_ch = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) top_ch = SW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    ch_nxt    = y_ch;
    last_nxt  = y_last;
    ptr_nxt   = ptr;
    if (free) begin
      state_nxt = EMPTY;
      y_nxt     = '0;
      ch_nxt    = '0;
      last_nxt  = 1'b0;
      if (e) begin
        if (!mode) begin
          if (s_legal) begin
            state_nxt = FULL;
            y_nxt     = sel_data;
            ch_nxt    = s;
          end
        end else if (scan_hit) begin
          state_nxt = FULL;
          y_nxt     = scan_data;
          ch_nxt    = scan_ch;
          last_nxt  = (scan_ch == top_ch);
          ptr_nxt   = (int'(scan_ch) == N - 1) ? '0 : scan_ch + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      y      <= '0;
      y_ch   <= '0;
      y_last <= 1'b0;
      ptr    <= '0;
    end else begin
      state  <= state_nxt;
      y      <= y_nxt;
      y_ch   <= ch_nxt;
      y_last <= last_nxt;
      ptr    <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_mux_rr.sv
// Bench for tdm_mux_rr: N=4 and N=3 instances share stimulus and are each
// compared against a word-level reference model every cycle.
module tb_tdm_mux_rr;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst, e, mode, y_ready;
  logic [SW-1:0] s;
  logic [3:0]    mask;
  logic [31:0]   d;

  logic [W-1:0]  y0, y1;
  logic [SW-1:0] y_ch0, y_ch1;
  logic          y_last0, y_last1, y_valid0, y_valid1;

  int checks = 0;
  int errors = 0;

  bit         m_valid [2];
  logic [7:0] m_y     [2];
  int         m_ch    [2];
  bit         m_last  [2];
  int         m_ptr   [2];

  always #5 clk = ~clk;

  tdm_mux_rr #(.N(4), .W(W), .SW(SW)) dut0 (
    .clk(clk), .rst(rst), .e(e), .mode(mode), .s(s), .mask(mask), .d(d),
    .y(y0), .y_ch(y_ch0), .y_last(y_last0), .y_valid(y_valid0), .y_ready(y_ready)
  );

  tdm_mux_rr #(.N(3), .W(W), .SW(SW)) dut1 (
    .clk(clk), .rst(rst), .e(e), .mode(mode), .s(s), .mask(mask[2:0]), .d(d[23:0]),
    .y(y1), .y_ch(y_ch1), .y_last(y_last1), .y_valid(y_valid1), .y_ready(y_ready)
  );

  task automatic model_update(input int u, input int n);
    bit found;
    int c, hi;
    if (rst) begin
      m_valid[u] = 0; m_y[u] = 0; m_ch[u] = 0; m_last[u] = 0; m_ptr[u] = 0;
    end else if (!m_valid[u] || y_ready) begin
      m_valid[u] = 0; m_y[u] = 0; m_ch[u] = 0; m_last[u] = 0;
      if (e && !mode && int'(s) < n) begin
        m_valid[u] = 1;
        m_y[u]     = d[int'(s)*W +: W];
        m_ch[u]    = int'(s);
      end else if (e && mode) begin
        found = 0;
        c     = 0;
        for (int k = 0; k < n; k++) begin
          if (!found && mask[(m_ptr[u] + k) % n]) begin
            found = 1;
            c     = (m_ptr[u] + k) % n;
          end
        end
        hi = -1;
        for (int i = 0; i < n; i++) if (mask[i]) hi = i;
        if (found) begin
          m_valid[u] = 1;
          m_y[u]     = d[c*W +: W];
          m_ch[u]    = c;
          m_last[u]  = (c == hi);
          m_ptr[u]   = (c + 1) % n;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_models();
    chk("dut0.y_valid", 32'(y_valid0), 32'(m_valid[0]));
    chk("dut0.y", 32'(y0), 32'(m_y[0]));
    if (m_valid[0]) begin
      chk("dut0.y_ch", 32'(y_ch0), 32'(m_ch[0]));
      chk("dut0.y_last", 32'(y_last0), 32'(m_last[0]));
    end
    chk("dut1.y_valid", 32'(y_valid1), 32'(m_valid[1]));
    chk("dut1.y", 32'(y1), 32'(m_y[1]));
    if (m_valid[1]) begin
      chk("dut1.y_ch", 32'(y_ch1), 32'(m_ch[1]));
      chk("dut1.y_last", 32'(y_last1), 32'(m_last[1]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update(0, 4);
    model_update(1, 3);
    #1;
    check_models();
  endtask

  initial begin
    logic [7:0] held;
    int exp_ch   [4];
    int exp_last [4];
    exp_ch   = '{1, 3, 1, 3};
    exp_last = '{0, 1, 0, 1};
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0; m_y[u] = 0; m_ch[u] = 0; m_last[u] = 0; m_ptr[u] = 0;
    end
    rst = 1; e = 0; mode = 0; s = 0; mask = 0; d = 0; y_ready = 0;
    cycle();
    cycle();
    chk("reset_valid", 32'(y_valid0), 0);
    rst = 0;

    // direct select; s=3 is illegal for the N=3 instance
    d = 32'h44332211; e = 1; mode = 0; y_ready = 1;
    for (int i = 0; i < 4; i++) begin
      s = SW'(i);
      cycle();
      chk("direct_y", 32'(y0), 32'h11 * (i + 1));
      chk("direct_ch", 32'(y_ch0), i);
      if (i == 3) chk("illegal_n3_valid", 32'(y_valid1), 0);
    end

    // scan with holes
    mode = 1; mask = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("holes_ch", 32'(y_ch0), exp_ch[i]);
      chk("holes_last", 32'(y_last0), exp_last[i]);
    end
    mask = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("single_ch", 32'(y_ch0), 2);
      chk("single_last", 32'(y_last0), 1);
    end

    // backpressure while ch1 is held (ptr=3 -> loads 3,0,1)
    mask = 4'hF;
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_pre_ch", 32'(y_ch0), 1);
    held = y0;
    y_ready = 0;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      cycle();
      chk("bp_hold_ch", 32'(y_ch0), 1);
      chk("bp_hold_y", 32'(y0), 32'(held));
    end
    y_ready = 1;
    cycle();
    chk("bp_release_ch", 32'(y_ch0), 2);

    // enable low, then empty mask
    e = 0;
    cycle();
    cycle();
    chk("e0_valid", 32'(y_valid0), 0);
    e = 1;
    cycle();
    chk("e_resume_ch", 32'(y_ch0), 3);
    mask = 4'h0;
    cycle();
    chk("mask0_valid", 32'(y_valid0), 0);
    mask = 4'hF;
    cycle();
    chk("wrap_ch", 32'(y_ch0), 0);

    // mode switch keeps ptr
    cycle();
    mode = 0; s = 0;
    cycle();
    cycle();
    chk("mode0_ch", 32'(y_ch0), 0);
    mode = 1;
    cycle();
    chk("mode_resume_ch", 32'(y_ch0), 2);

    // reset mid-stall
    y_ready = 0;
    cycle();
    rst = 1;
    cycle();
    chk("rst_stall_valid", 32'(y_valid0), 0);
    rst = 0; y_ready = 1;
    cycle();
    chk("rst_ptr_ch", 32'(y_ch0), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      e       = ($urandom_range(0, 7) != 0);
      mode    = ($urandom_range(0, 2) != 0);
      s       = SW'($urandom);
      mask    = 4'($urandom);
      d       = $urandom;
      y_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
